// File: rtl/input_conditioner.sv
// Cabinet input front end: per-bit sync + tick-gated debounce, coin pulse shaping, mode-change blanking.
// Optional autofire on masked bits when INPUT_CONDITIONER_AUTOFIRE_EN is defined.

module input_conditioner_lane #(
  parameter int DB_W = 2
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic stable
);
  // Flip on the tick that brings the run of disagreeing samples to 2^DB_W-1.
  localparam logic [DB_W-1:0] LAST = DB_W'((1 << DB_W) - 2);

  logic            s1, s2;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (tick) begin
        if (s2 == stable) cnt <= '0;
        else if (cnt == LAST) begin
          stable <= s2;
          cnt    <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module input_conditioner #(
  parameter int                    NUM_INPUTS = 13,
  parameter int                    DB_W       = 2,
  parameter int                    COIN_IDX   = 8,
  parameter int                    COIN_TICKS = 4,
  parameter int                    MODE_W     = 2,
  parameter int                    MODE_BLANK = 8,
  parameter logic [NUM_INPUTS-1:0] AF_MASK    = 13'h1800,
  parameter int                    AF_PERIOD  = 3
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic [MODE_W-1:0]     mode,
  input  logic [NUM_INPUTS-1:0] raw,
  output logic [NUM_INPUTS-1:0] cond,
  output logic                  coin_pulse,
  output logic                  busy
);
  localparam int CCW = $clog2(COIN_TICKS + 1);
  localparam int BCW = $clog2(MODE_BLANK + 1);
  // An out-of-range COIN_IDX shifts out to an all-zero mask, disabling the coin path.
  localparam logic [NUM_INPUTS-1:0] COIN_M = NUM_INPUTS'(1) << COIN_IDX;
  localparam logic [NUM_INPUTS-1:0] AF_M   = AF_MASK & ~COIN_M;

  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_LOCK} coin_st_t;

  logic [NUM_INPUTS-1:0] stable, cond_nxt, cond_q;
  logic [MODE_W-1:0]     mode_q;
  logic [BCW-1:0]        blank_cnt;
  logic                  busy_q, mode_chg;
  coin_st_t              coin_st;
  logic [CCW-1:0]        coin_cnt;
  logic                  coin_lvl, coin_prev, coin_q;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    input_conditioner_lane #(.DB_W(DB_W)) u_lane (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .tick    (tick),
      .raw     (raw[i]),
      .stable  (stable[i])
    );
  end

  assign mode_chg = (mode != mode_q);
  assign coin_lvl = |(stable & COIN_M);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= '0;
      blank_cnt <= '0;
      busy_q    <= 1'b0;
    end else begin
      mode_q <= mode;
      if (mode_chg) begin
        blank_cnt <= BCW'(MODE_BLANK);
        busy_q    <= 1'b1;
      end else if (busy_q) begin
        if (blank_cnt == '0) busy_q <= 1'b0;
        else if (tick) blank_cnt <= blank_cnt - 1'b1;
      end
    end
  end

  // While blanked, park in LOCK if the coin is down so a held coin never pulses afterwards.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      coin_st   <= C_IDLE;
      coin_cnt  <= '0;
      coin_prev <= 1'b0;
      coin_q    <= 1'b0;
    end else begin
      coin_prev <= coin_lvl;
      if (mode_chg) begin
        coin_st <= C_IDLE;
        coin_q  <= 1'b0;
      end else if (busy_q) begin
        coin_st <= coin_lvl ? C_LOCK : C_IDLE;
        coin_q  <= 1'b0;
      end else begin
        case (coin_st)
          C_IDLE: if (coin_lvl && !coin_prev) begin
            coin_st  <= C_PULSE;
            coin_cnt <= CCW'(COIN_TICKS);
            coin_q   <= 1'b1;
          end
          C_PULSE: if (tick) begin
            if (coin_cnt == CCW'(1)) begin
              coin_st <= C_LOCK;
              coin_q  <= 1'b0;
            end else coin_cnt <= coin_cnt - 1'b1;
          end
          C_LOCK: if (!coin_lvl) coin_st <= C_IDLE;
          default: coin_st <= C_IDLE;
        endcase
      end
    end
  end

`ifdef INPUT_CONDITIONER_AUTOFIRE_EN
  localparam int ACW = $clog2(AF_PERIOD + 1);

  logic [ACW-1:0]        af_cnt;
  logic                  af_phase, af_phase_nxt, af_restart;
  logic [NUM_INPUTS-1:0] af_prev;

  assign af_restart = |(stable & ~af_prev & AF_M);

  // Next phase feeds cond directly so a fresh press fires on its first clock.
  always_comb begin
    af_phase_nxt = af_phase;
    if (af_restart) af_phase_nxt = 1'b1;
    else if (tick && af_cnt == ACW'(AF_PERIOD - 1)) af_phase_nxt = ~af_phase;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
      af_prev  <= '0;
    end else begin
      af_prev  <= stable & AF_M;
      af_phase <= af_phase_nxt;
      if (af_restart) af_cnt <= '0;
      else if (tick) af_cnt <= (af_cnt == ACW'(AF_PERIOD - 1)) ? '0 : af_cnt + 1'b1;
    end
  end

  assign cond_nxt = (stable & ~AF_M) | (stable & AF_M & {NUM_INPUTS{af_phase_nxt}});
`else
  // The mask term is absorbed by the OR: masked bits pass as plain levels.
  assign cond_nxt = stable | (stable & AF_M & {NUM_INPUTS{AF_PERIOD > 0}});
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) cond_q <= '0;
    else          cond_q <= cond_nxt;
  end

  assign cond       = busy_q ? '0 : ((cond_q & ~COIN_M) | (COIN_M & {NUM_INPUTS{coin_q}}));
  assign coin_pulse = coin_q;
  assign busy       = busy_q;
endmodule
